fpu_addsub_param: RTL and testbench

Parametrised multi-cycle floating-point adder/subtractor for the team's custom sign/exponent/mantissa format. It replaces the free-running adder with the following:
- a start/done handshake;
- an add/subtract mode;
- guard/round/sticky alignment and round-to-nearest-even;
- one-hot status.

It sits on the 100 kHz datapath and is driven by the control FSM, one operation at a time.

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fpu_lzc.sv | 18 +
 rtl/fpu_addsub_param.sv | 211 +++++++++++++++++++++
 tb/tb_fpu_addsub_param.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the sign/exponent/mantissa add/subtract unit:
// controller states, status bit positions and the default exponent bias.
package fpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_PACK  = 3'd5
    } state_t;

    localparam int ST_EXACT     = 0;
    localparam int ST_INEXACT   = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_UNDERFLOW = 3;

    // Bias that centres the exponent range: 2^(exp_w-1) - 1.
    function automatic int default_bias(input int exp_w);
        return (2 ** (exp_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter. An all-zero input reports WIDTH.
module fpu_lzc #(
    parameter int  WIDTH = 29,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din,
    output logic [CW-1:0]    count
);

    // Scan upward so the highest set bit is the last one to set the count.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (din[i]) count = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fpu_addsub_param.sv
// Multi-cycle floating-point adder/subtractor with start/done handshake,
// guard/round/sticky alignment, round-to-nearest-even and one-hot status.
// Handshake: start is sampled only while idle (busy low); done is a one-cycle
// pulse and data_out/status_out hold their value until the next done.
// Optional build macro FPU_TRUNC_MODE_EN adds the round_mode input
// (0 = nearest-even, 1 = truncate toward zero).
module fpu_addsub_param
    import fpu_pkg::*;
#(
    parameter int  EXP_W = 6,
    parameter int  MAN_W = 25,
    parameter int  BIAS  = default_bias(EXP_W),
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clock100KHz,
    input  logic         reset,
    input  logic         start,
    input  logic         op_sub,
`ifdef FPU_TRUNC_MODE_EN
    input  logic         round_mode,
`endif
    input  logic [W-1:0] op_A_in,
    input  logic [W-1:0] op_B_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] data_out,
    output logic [3:0]   status_out
);

    localparam int XW   = MAN_W + 4;          // {hidden, mant, G, R, S}
    localparam int EW   = EXP_W + 2;          // signed exponent, no wrap
    localparam int CW   = $clog2(XW + 1);
    localparam int EMAX = (2 ** EXP_W) - 1;

    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);
    localparam logic signed [EW-1:0] ONE_S  = EW'(1);

    localparam logic [3:0] STAT_EXACT   = 4'(1 << ST_EXACT);
    localparam logic [3:0] STAT_INEXACT = 4'(1 << ST_INEXACT);
    localparam logic [3:0] STAT_OVF     = 4'(1 << ST_OVERFLOW);
    localparam logic [3:0] STAT_UNF     = 4'(1 << ST_UNDERFLOW);

    state_t               state;
    logic                 sa_q, sb_q;
    logic [EXP_W-1:0]     ea_q, eb_q;
    logic [MAN_W-1:0]     ma_q, mb_q;
    logic [XW-1:0]        mx_q, my_q;
    logic                 sx_q, sy_q;
    logic signed [EW-1:0] e_q;
    logic                 byp_q;
    logic [W-1:0]         byp_word_q;
    logic [XW:0]          sum_q;
    logic [XW-1:0]        mn_q;
    logic [MAN_W-1:0]     mant_q;
    logic                 inex_q;
    logic                 trunc_sel;

    assign busy = (state != S_IDLE);

`ifdef FPU_TRUNC_MODE_EN
    logic rmode_q;
    // Rounding mode is captured together with the operands.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset)                        rmode_q <= 1'b0;
        else if (state == S_IDLE && start) rmode_q <= round_mode;
    end
    assign trunc_sel = rmode_q;
`else
    assign trunc_sel = 1'b0;
`endif

    // Alignment: larger magnitude becomes X, smaller is shifted with sticky.
    logic             a_zero, b_zero, a_big, sticky;
    logic [EXP_W-1:0] ediff, e_big;
    logic [XW-1:0]    ext_big, ext_small, small_al;
    logic [W-1:0]     byp_word_c;
    always_comb begin
        a_zero    = (ea_q == '0);
        b_zero    = (eb_q == '0);
        a_big     = (ea_q > eb_q) || ((ea_q == eb_q) && (ma_q >= mb_q));
        ediff     = a_big ? (ea_q - eb_q) : (eb_q - ea_q);
        e_big     = a_big ? ea_q : eb_q;
        ext_big   = a_big ? {1'b1, ma_q, 3'b000} : {1'b1, mb_q, 3'b000};
        ext_small = a_big ? {1'b1, mb_q, 3'b000} : {1'b1, ma_q, 3'b000};
        sticky    = |(ext_small & ~({XW{1'b1}} << ediff));
        if (int'(ediff) >= (MAN_W + 3)) small_al = XW'(1);
        else                            small_al = (ext_small >> ediff) | XW'(sticky);
        if (a_zero && b_zero) byp_word_c = {sa_q & sb_q, {(W-1){1'b0}}};
        else if (a_zero)      byp_word_c = {sb_q, eb_q, mb_q};
        else                  byp_word_c = {sa_q, ea_q, ma_q};
    end

    logic [CW-1:0] lzc_cnt;
    fpu_lzc #(.WIDTH(XW)) u_lzc (
        .din   (sum_q[XW-1:0]),
        .count (lzc_cnt)
    );

    // Rounding increment on the normalised significand (LSB is bit 3).
    logic             rnd_up;
    logic [MAN_W+1:0] rnd;
    always_comb begin
        rnd_up = mn_q[2] & (mn_q[1] | mn_q[0] | mn_q[3]) & ~trunc_sel;
        rnd    = {1'b0, mn_q[XW-1:3]} + {{(MAN_W+1){1'b0}}, rnd_up};
    end

    logic signed [EW-1:0] e_biased;
    assign e_biased = e_q + BIAS_S;

    // Controller and datapath: one pipeline step per state, one op at a time.
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            done       <= 1'b0;
            data_out   <= '0;
            status_out <= STAT_EXACT;
            sa_q       <= 1'b0;
            sb_q       <= 1'b0;
            ea_q       <= '0;
            eb_q       <= '0;
            ma_q       <= '0;
            mb_q       <= '0;
            mx_q       <= '0;
            my_q       <= '0;
            sx_q       <= 1'b0;
            sy_q       <= 1'b0;
            e_q        <= '0;
            byp_q      <= 1'b0;
            byp_word_q <= '0;
            sum_q      <= '0;
            mn_q       <= '0;
            mant_q     <= '0;
            inex_q     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sa_q  <= op_A_in[W-1];
                        sb_q  <= op_B_in[W-1] ^ op_sub;
                        ea_q  <= op_A_in[W-2 -: EXP_W];
                        eb_q  <= op_B_in[W-2 -: EXP_W];
                        ma_q  <= op_A_in[MAN_W-1:0];
                        mb_q  <= op_B_in[MAN_W-1:0];
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    mx_q       <= ext_big;
                    my_q       <= small_al;
                    sx_q       <= a_big ? sa_q : sb_q;
                    sy_q       <= a_big ? sb_q : sa_q;
                    e_q        <= $signed({2'b00, e_big}) - BIAS_S;
                    byp_q      <= a_zero | b_zero;
                    byp_word_q <= byp_word_c;
                    state      <= S_ADD;
                end
                S_ADD: begin
                    if (sx_q == sy_q) sum_q <= {1'b0, mx_q} + {1'b0, my_q};
                    else              sum_q <= {1'b0, mx_q} - {1'b0, my_q};
                    // Exact cancellation always gives +0.
                    if ((sx_q != sy_q) && (mx_q == my_q) && !byp_q) begin
                        byp_q      <= 1'b1;
                        byp_word_q <= '0;
                    end
                    state <= S_NORM;
                end
                S_NORM: begin
                    if (sum_q[XW]) begin
                        mn_q <= {sum_q[XW:2], sum_q[1] | sum_q[0]};
                        e_q  <= e_q + ONE_S;
                    end else begin
                        mn_q <= sum_q[XW-1:0] << lzc_cnt;
                        e_q  <= e_q - $signed(EW'(lzc_cnt));
                    end
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    inex_q <= |mn_q[2:0];
                    if (rnd[MAN_W+1]) begin
                        mant_q <= rnd[MAN_W:1];
                        e_q    <= e_q + ONE_S;
                    end else begin
                        mant_q <= rnd[MAN_W-1:0];
                    end
                    state <= S_PACK;
                end
                S_PACK: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                    if (byp_q) begin
                        data_out   <= byp_word_q;
                        status_out <= STAT_EXACT;
                    end else if (e_biased > EMAX_S) begin
                        data_out   <= {sx_q, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
                        status_out <= STAT_OVF;
                    end else if (e_biased < ONE_S) begin
                        data_out   <= '0;
                        status_out <= STAT_UNF;
                    end else begin
                        data_out   <= {sx_q, e_biased[EXP_W-1:0], mant_q};
                        status_out <= inex_q ? STAT_INEXACT : STAT_EXACT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Bench for fpu_addsub_param at default parameters: directed corner cases,
// control corner cases and randomized operands against an exact-arithmetic
// reference model.
`timescale 1ns/1ps
module tb_fpu_addsub_param;

    logic        clock100KHz = 1'b0;
    logic        reset;
    logic        start;
    logic        op_sub;
    logic [31:0] op_A_in;
    logic [31:0] op_B_in;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
    logic [3:0]  status_out;

    int          total = 0;
    int          bad   = 0;
    logic [35:0] exp_q[$];      // {status, data} expected per done pulse
    logic [35:0] cmp_want;

    fpu_addsub_param dut (
        .clock100KHz (clock100KHz),
        .reset       (reset),
        .start       (start),
        .op_sub      (op_sub),
`ifdef FPU_TRUNC_MODE_EN
        .round_mode  (1'b0),
`endif
        .op_A_in     (op_A_in),
        .op_B_in     (op_B_in),
        .busy        (busy),
        .done        (done),
        .data_out    (data_out),
        .status_out  (status_out)
    );

    // ---------------- clock / reset ----------------
    always #5000 clock100KHz = ~clock100KHz;

    initial begin
        #400000000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    // Exact sum of the two values as wide integers, then round to 26
    // significant bits with nearest-even and check the exponent range.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub);
        logic         sa, sb, s, inexact, up;
        int           ea, eb, emin, msb, sh, biased;
        logic [127:0] ma, mb, mag, kept, rem, half;
        sa = a[31];
        sb = b[31] ^ sub;
        ea = int'(a[30:25]);
        eb = int'(b[30:25]);
        if (ea == 0 && eb == 0) return {4'b0001, sa & sb, 31'd0};
        if (ea == 0)            return {4'b0001, sb, b[30:0]};
        if (eb == 0)            return {4'b0001, sa, a[30:0]};
        emin = (ea < eb) ? ea : eb;
        ma = {102'd0, 1'b1, a[24:0]} << (ea - emin);
        mb = {102'd0, 1'b1, b[24:0]} << (eb - emin);
        if (sa == sb)     begin mag = ma + mb; s = sa; end
        else if (ma > mb) begin mag = ma - mb; s = sa; end
        else if (mb > ma) begin mag = mb - ma; s = sb; end
        else return {4'b0001, 32'd0};
        msb = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) msb = i;
        sh = msb - 25;
        inexact = 1'b0;
        if (sh > 0) begin
            kept    = mag >> sh;
            rem     = mag & ((128'd1 << sh) - 128'd1);
            half    = 128'd1 << (sh - 1);
            inexact = (rem != 128'd0);
            up      = (rem > half) || ((rem == half) && kept[0]);
            kept    = kept + {127'd0, up};
            if (kept[26]) begin kept = kept >> 1; sh++; end
        end else begin
            kept = mag << (-sh);
        end
        biased = emin + sh;
        if (biased > 63) return {4'b0100, s, 6'h3F, 25'h1FFFFFF};
        if (biased < 1)  return {4'b1000, 32'd0};
        return {(inexact ? 4'b0010 : 4'b0001), s, 6'(biased), kept[24:0]};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clock100KHz) begin
        if (reset === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: done pulse with data=%0h and nothing pending", data_out);
            end else begin
                cmp_want = exp_q.pop_front();
                check("data_out", {32'd0, data_out}, {32'd0, cmp_want[31:0]});
                check("status_out", {60'd0, status_out}, {60'd0, cmp_want[35:32]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input bit wait_first);
        if (wait_first) @(negedge clock100KHz);
        op_A_in = a;
        op_B_in = b;
        op_sub  = sub;
        start   = 1'b1;
        @(posedge clock100KHz);
        @(negedge clock100KHz);
        start = 1'b0;
    endtask

    // Called at the negedge after the launch edge; returns in the done cycle.
    task automatic track(input string tag, input bit poke);
        int lat;
        lat = -1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clock100KHz);
            if (poke && k == 1) begin
                op_A_in = 32'h7FFFFFFF;
                op_B_in = 32'h7FFFFFFF;
                op_sub  = 1'b0;
                start   = 1'b1;
            end
            if (poke && k == 3) start = 1'b0;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            check({tag, "_busy"}, {63'd0, busy}, 64'd1);
        end
        check({tag, "_latency"}, 64'(lat), 64'd5);
        check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [35:0] want, input bit poke);
        exp_q.push_back(want);
        launch(a, b, sub, 1'b1);
        track(tag, poke);
    endtask

    task automatic rand_ops(output logic [31:0] a, output logic [31:0] b, output logic sub);
        int mode, e;
        a    = $urandom;
        b    = $urandom;
        sub  = 1'($urandom_range(0, 1));
        mode = int'($urandom_range(0, 9));
        case (mode)
            0, 1, 2, 3: begin
                e = int'(a[30:25]) + int'($urandom_range(0, 6)) - 3;
                if (e < 0)  e = 0;
                if (e > 63) e = 63;
                b[30:25] = 6'(e);
            end
            4: begin
                b      = a;
                b[2:0] = 3'($urandom);
            end
            5: begin
                if ($urandom_range(0, 1) == 1) a[30:25] = 6'd0;
                else                           b[30:25] = 6'd0;
            end
            6: begin
                a[30:25] = 6'($urandom_range(60, 63));
                b[30:25] = 6'($urandom_range(60, 63));
            end
            7: begin
                a[30:25] = 6'($urandom_range(1, 4));
                b[30:25] = 6'($urandom_range(1, 4));
            end
            default: ;
        endcase
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          dones;

        reset   = 1'b0;
        start   = 1'b0;
        op_sub  = 1'b0;
        op_A_in = '0;
        op_B_in = '0;
        repeat (3) @(negedge clock100KHz);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_data", {32'd0, data_out}, 64'd0);
        check("rst_status", {60'd0, status_out}, 64'h1);
        reset = 1'b1;

        // Hand-computed values pin the model itself.
        check("pin_1p1",   64'(model(32'h3E000000, 32'h3E000000, 1'b0)), 64'h0_40000000 | (64'h1 << 32));
        check("pin_1m1",   64'(model(32'h3E000000, 32'h3E000000, 1'b1)), 64'h1_00000000);
        check("pin_tie",   64'(model(32'h3E000000, 32'h0A000000, 1'b0)), 64'h2_3E000000);
        check("pin_rup",   64'(model(32'h3E000000, 32'h0B000000, 1'b0)), 64'h2_3E000001);
        check("pin_ovf",   64'(model(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0)), 64'h4_7FFFFFFF);
        check("pin_unf",   64'(model(32'h03000000, 32'h02000000, 1'b1)), 64'h8_00000000);
        check("pin_flush", 64'(model(32'h01FFFFFF, 32'h3E000000, 1'b1)), 64'h1_BE000000);

        // Directed operations with literal expectations.
        run_op("one_plus_one",  32'h3E000000, 32'h3E000000, 1'b0, 36'h1_40000000, 1'b0);
        run_op("one_minus_one", 32'h3E000000, 32'h3E000000, 1'b1, 36'h1_00000000, 1'b0);
        run_op("tie_even",      32'h3E000000, 32'h0A000000, 1'b0, 36'h2_3E000000, 1'b0);
        run_op("round_up",      32'h3E000000, 32'h0B000000, 1'b0, 36'h2_3E000001, 1'b0);
        run_op("overflow",      32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 36'h4_7FFFFFFF, 1'b0);
        run_op("underflow",     32'h03000000, 32'h02000000, 1'b1, 36'h8_00000000, 1'b0);
        run_op("flush_zero",    32'h01FFFFFF, 32'h3E000000, 1'b1, 36'h1_BE000000, 1'b0);
        run_op("neg_zeros",     32'h80000000, 32'h00000000, 1'b1, 36'h1_80000000, 1'b0);

        // start while busy must be ignored (junk operands would overflow).
        run_op("start_busy",    32'h3E000000, 32'h3E000000, 1'b0, 36'h1_40000000, 1'b1);

        // Back-to-back: second start presented in the done cycle of the first.
        run_op("b2b_first",     32'h3E000000, 32'h0B000000, 1'b0, 36'h2_3E000001, 1'b0);
        exp_q.push_back(36'h1_40000000);
        launch(32'h3E000000, 32'h3E000000, 1'b0, 1'b0);
        track("b2b_second", 1'b0);

        // Reset during ADD aborts the operation with no done pulse.
        launch(32'h3E000000, 32'h0B000000, 1'b0, 1'b1);
        @(negedge clock100KHz);
        reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_data", {32'd0, data_out}, 64'd0);
        check("abort_status", {60'd0, status_out}, 64'h1);
        @(negedge clock100KHz);
        reset = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock100KHz);
            if (done === 1'b1) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);

        // Randomized operands against the model.
        for (int n = 0; n < 300; n++) begin
            rand_ops(ra, rb, rs);
            run_op("rand", ra, rb, rs, model(ra, rb, rs), ($urandom_range(0, 7) == 0));
        end

        repeat (3) @(negedge clock100KHz);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
